// File: rtl/symbol_grid_sequencer.sv
// symbol_grid_sequencer
//   Upstream controller for the per-symbol pixel drawer. Walks a ROWS x COLS grid of
//   symbol slots in row-major order. For each slot it presents the base (x,y), holds the
//   drawer enable high until the drawer's completion pulse, drops it for one cycle, then
//   moves on. It also delays the enable by one clock to form the VGA plot strobe, and
//   reports busy/done to the game FSM.
//
// Optional feature macro: SEQ_WATCHDOG_EN
//   When defined, a DRAW-state watchdog forces the slot to complete after WDOG_CYCLES
//   DRAW cycles and raises a sticky wdog_err. When undefined, wdog_err is tied low.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   begin a full-grid pass (only honoured in IDLE)
//   sym_done  in   drawer completion pulse (only honoured in DRAW)
//   sym_x     out  [7:0] base x to drawer
//   sym_y     out  [6:0] base y to drawer
//   sym_go    out  drawer enable; low clears the drawer counter
//   plot      out  VGA write enable, sym_go delayed one clk
//   slot_idx  out  [6:0] current slot index
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse at end of pass
//   wdog_err  out  sticky watchdog flag
module symbol_grid_sequencer #(
  parameter int unsigned COLS        = 4,
  parameter int unsigned ROWS        = 3,
  parameter logic [7:0]  X0          = 8'd8,
  parameter logic [6:0]  Y0          = 7'd8,
  parameter logic [7:0]  X_PITCH     = 8'd20,
  parameter logic [6:0]  Y_PITCH     = 7'd20,
  parameter logic [7:0]  WDOG_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sym_done,
  output logic [7:0] sym_x,
  output logic [6:0] sym_y,
  output logic       sym_go,
  output logic       plot,
  output logic [6:0] slot_idx,
  output logic       busy,
  output logic       done,
  output logic       wdog_err
);

  localparam logic [3:0] ColLast = 4'(COLS - 1);
  localparam logic [2:0] RowLast = 3'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDraw,
    StGap,
    StFinish
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [6:0] slot_q, slot_d;
  logic       go_q, plot_q, busy_q, done_q;
  logic       wdog_trip;

  // Next-state and slot-advance logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    slot_d  = slot_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          col_d   = 4'd0;
          row_d   = 3'd0;
          slot_d  = 7'd0;
          x_d     = X0;
          y_d     = Y0;
        end
      end
      StLoad: state_d = StDraw;
      StDraw: begin
        if (sym_done || wdog_trip) begin
          state_d = StGap;
        end
      end
      StGap: begin
        // Base moves while sym_go is low, so the drawer sees the new (x,y) on its rise
        if (col_q < ColLast) begin
          col_d = col_q + 4'd1;
          x_d   = x_q + X_PITCH;
        end else begin
          col_d = 4'd0;
          x_d   = X0;
          row_d = row_q + 3'd1;
          y_d   = y_q + Y_PITCH;
        end
        slot_d = slot_q + 7'd1;
        if ((row_q == RowLast) && (col_q == ColLast)) begin
          state_d = StFinish;
        end else begin
          state_d = StDraw;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      col_q   <= 4'd0;
      row_q   <= 3'd0;
      x_q     <= X0;
      y_q     <= Y0;
      slot_q  <= 7'd0;
      go_q    <= 1'b0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      slot_q  <= slot_d;
      // Enable trails the DRAW state by one clock: LOAD->DRAW gives the two-edge start
      // latency, and GAP yields exactly one low cycle between slots.
      go_q    <= (state_q == StDraw);
      plot_q  <= go_q;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFinish);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] wdog_cnt_q, wdog_cnt_d;
  logic       wdog_err_q, wdog_err_d;

  // Counter holds the number of DRAW cycles already spent on this slot; it is zero
  // outside DRAW, so it is implicitly cleared on every DRAW entry.
  assign wdog_trip = (state_q == StDraw) && (wdog_cnt_q == (WDOG_CYCLES - 8'd1));

  always_comb begin
    wdog_cnt_d = (state_q == StDraw) ? (wdog_cnt_q + 8'd1) : 8'd0;
    wdog_err_d = wdog_err_q;
    if ((state_q == StIdle) && start) begin
      wdog_err_d = 1'b0;
    end else if (wdog_trip && !sym_done) begin
      wdog_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= 8'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_trip   = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  assign sym_x    = x_q;
  assign sym_y    = y_q;
  assign sym_go   = go_q;
  assign plot     = plot_q;
  assign slot_idx = slot_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_symbol_grid_sequencer.sv
// Directed bench for symbol_grid_sequencer: a drawer model answers each sym_go rise,
// per-slot base/index expectations come from a table, plus reset and watchdog sequences.
module tb_symbol_grid_sequencer;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [7:0] TbWdog   = 8'd10;
  localparam int         DrawLat  = 5;
  localparam int         HoldCnt  = 3;
`else
  localparam logic [7:0] TbWdog   = 8'd255;
  localparam int         DrawLat  = 51;
  localparam int         HoldCnt  = 20;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       sym_done;
  logic [7:0] sym_x;
  logic [6:0] sym_y;
  logic       sym_go;
  logic       plot;
  logic [6:0] slot_idx;
  logic       busy;
  logic       done;
  logic       wdog_err;

  symbol_grid_sequencer #(
    .WDOG_CYCLES(TbWdog)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sym_done (sym_done),
    .sym_x    (sym_x),
    .sym_y    (sym_y),
    .sym_go   (sym_go),
    .plot     (plot),
    .slot_idx (slot_idx),
    .busy     (busy),
    .done     (done),
    .wdog_err (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] idx;
    logic [7:0] x;
    logic [6:0] y;
  } slot_vec_t;

  slot_vec_t tbl[12];
  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(sym_x), 32'd8);
    check({tag, "_y"}, 32'(sym_y), 32'd8);
    check({tag, "_slot"}, 32'(slot_idx), 32'd0);
    check({tag, "_go"}, 32'(sym_go), 32'd0);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wdog"}, 32'(wdog_err), 32'd0);
  endtask

  // Full pass with drawer model. lat=0: drawer never answers (watchdog run).
  task automatic run_pass(input int lat, input bit poke);
    int  rises, dones, low_run, go_cnt;
    bit  prev, finished;
    rises = 0; dones = 0; low_run = 0; go_cnt = 0; finished = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_go_low", 32'(sym_go), 32'd0);
    check("start_wdog_clr", 32'(wdog_err), 32'd0);
    @(negedge clk);
    check("load_go_low", 32'(sym_go), 32'd0);
    for (int b = 0; b < 3000 && !finished; b++) begin
      prev = sym_go;
      @(negedge clk);
      sym_done = 1'b0;
      start    = 1'b0;
      if (b == 0) check("go_latency", 32'(sym_go), 32'd1);
      if (plot !== prev) check("plot_delay", 32'(plot), 32'(prev));
      if (!sym_go && prev && lat == 0) check("wdog_run", 32'(go_cnt), 32'(TbWdog));
      if (sym_go && !prev) begin
        if (rises < 12) begin
          check("slot_idx", 32'(slot_idx), 32'(tbl[rises].idx));
          check("slot_x", 32'(sym_x), 32'(tbl[rises].x));
          check("slot_y", 32'(sym_y), 32'(tbl[rises].y));
        end
        if (rises > 0) check("gap_len", 32'(low_run), 32'd1);
        rises++;
        go_cnt = 0;
      end
      if (sym_go) begin
        go_cnt++;
        low_run = 0;
        if (lat != 0 && go_cnt == lat) sym_done = 1'b1;
      end else begin
        low_run++;
      end
      if (poke && rises == 6 && go_cnt == 10) start = 1'b1;
      if (done) begin
        dones++;
        check("end_x", 32'(sym_x), 32'd8);
        check("end_y", 32'(sym_y), 32'd68);
        check("end_slot", 32'(slot_idx), 32'd12);
        check("end_busy", 32'(busy), 32'd1);
      end
      if (dones > 0 && !busy) finished = 1'b1;
    end
    check("pass_timeout", 32'(finished), 32'd1);
    check("slot_count", 32'(rises), 32'd12);
    check("done_count", 32'(dones), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check("pass_wdog", 32'(wdog_err), 32'(lat == 0));
  endtask

  // Start a pass and stop mid-DRAW of the given slot (target = slot index + 1).
  task automatic draw_until(input int target);
    int rises, go_cnt;
    bit prev;
    rises = 0; go_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      prev = sym_go;
      @(negedge clk);
      sym_done = 1'b0;
      if (sym_go && !prev) begin
        rises++;
        go_cnt = 0;
      end
      if (sym_go) begin
        go_cnt++;
        if (go_cnt == DrawLat) sym_done = 1'b1;
      end
      if (rises == target && go_cnt == HoldCnt) break;
    end
    check("reach_slot", 32'(rises), 32'(target));
    check("reach_idx", 32'(slot_idx), 32'(target - 1));
  endtask

  task automatic quiet_after_reset(input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; start = 1'b0; sym_done = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        tbl[r*4+c].idx = 7'(r*4 + c);
        tbl[r*4+c].x   = 8'(8 + 20*c);
        tbl[r*4+c].y   = 7'(8 + 20*r);
      end
    end
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while idle: outputs must already be at reset values before any edge
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_idle");
    quiet_after_reset("idle_quiet");

    // Full pass, then a pass with a stray start pulse during slot 5
    run_pass(DrawLat, 1'b0);
    repeat (3) @(negedge clk);
    run_pass(DrawLat, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in DRAW of slot 0 and of slot 7: pass abandoned, no done
    draw_until(1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_draw0");
    quiet_after_reset("draw0_quiet");
    draw_until(8);
    check("slot7_go", 32'(sym_go), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_slot7");
    quiet_after_reset("slot7_quiet");
    run_pass(DrawLat, 1'b0);
    repeat (3) @(negedge clk);

    // Drawer never answers
`ifdef SEQ_WATCHDOG_EN
    run_pass(0, 1'b0);
    repeat (3) @(negedge clk);
    run_pass(DrawLat, 1'b0);
`else
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("stuck_dones", 32'(dones), 32'd0);
    end
    check("stuck_go", 32'(sym_go), 32'd1);
    check("stuck_slot", 32'(slot_idx), 32'd0);
    check("stuck_busy", 32'(busy), 32'd1);
    check("stuck_wdog", 32'(wdog_err), 32'd0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_stuck");
    quiet_after_reset("stuck_quiet");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
